// File: rtl/serial_acc_alu.sv
`default_nettype none
// ============================================================================
// Module  : serial_acc_alu
// Purpose : Bit-serial accumulator ALU. It adds or subtracts an operand, LSB
//           first, using one full-adder stage over WIDTH cycles.
// Rev     : 1.0  initial release
// ============================================================================
module serial_acc_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic             load,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc,
  output logic             busy,
  output logic             done,
  output logic             carry_flag,
  output logic             ovf_flag,
  output logic             zero_flag
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_cnt_one  = CW'(1);
  localparam logic [CW-1:0] c_cnt_last = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_carry, w_carry_nxt;
  logic             r_sub, w_sub_nxt;
  logic             r_a_msb, w_a_msb_nxt;
  logic             r_b_msb, w_b_msb_nxt;
  logic             r_done, w_done_nxt;
  logic             r_cf, w_cf_nxt;
  logic             r_of, w_of_nxt;
  logic             r_zf, w_zf_nxt;

  // One full-adder stage. Subtraction inverts B and seeds the carry with 1.
  logic             w_bit_b, w_s, w_cout;
  logic [WIDTH-1:0] w_rot;
  assign w_bit_b = r_b[0] ^ r_sub;
  assign w_s     = r_acc[0] ^ w_bit_b ^ r_carry;
  assign w_cout  = (r_acc[0] & w_bit_b) | ((r_acc[0] ^ w_bit_b) & r_carry);
  assign w_rot   = {w_s, r_acc[WIDTH-1:1]};

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_b_nxt     = r_b;
    w_cnt_nxt   = r_cnt;
    w_carry_nxt = r_carry;
    w_sub_nxt   = r_sub;
    w_a_msb_nxt = r_a_msb;
    w_b_msb_nxt = r_b_msb;
    w_done_nxt  = 1'b0;
    w_cf_nxt    = r_cf;
    w_of_nxt    = r_of;
    w_zf_nxt    = r_zf;
    case (r_state)
      S_IDLE: begin
        if (load) begin
          w_acc_nxt = operand;
          w_cf_nxt  = 1'b0;
          w_of_nxt  = 1'b0;
          w_zf_nxt  = (operand == '0);
        end else if (start) begin
          w_b_nxt     = operand;
          w_sub_nxt   = op_sub;
          w_carry_nxt = op_sub;
          w_cnt_nxt   = '0;
          w_a_msb_nxt = r_acc[WIDTH-1];
          w_b_msb_nxt = operand[WIDTH-1] ^ op_sub;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_acc_nxt   = w_rot;
        w_b_nxt     = r_b >> 1;
        w_carry_nxt = w_cout;
        w_cnt_nxt   = r_cnt + c_cnt_one;
        if (r_cnt == c_cnt_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_cf_nxt    = w_cout;
          w_zf_nxt    = (w_rot == '0);
          w_of_nxt    = (r_a_msb == r_b_msb) && (w_s != r_a_msb);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_done  <= 1'b0;
      r_cf    <= 1'b0;
      r_of    <= 1'b0;
      r_zf    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_b     <= w_b_nxt;
      r_cnt   <= w_cnt_nxt;
      r_carry <= w_carry_nxt;
      r_sub   <= w_sub_nxt;
      r_a_msb <= w_a_msb_nxt;
      r_b_msb <= w_b_msb_nxt;
      r_done  <= w_done_nxt;
      r_cf    <= w_cf_nxt;
      r_of    <= w_of_nxt;
      r_zf    <= w_zf_nxt;
    end
  end

  assign acc        = r_acc;
  assign busy       = (r_state == S_RUN);
  assign done       = r_done;
  assign carry_flag = r_cf;
  assign ovf_flag   = r_of;
  assign zero_flag  = r_zf;

endmodule
`default_nettype wire

// File: tb/tb_serial_acc_alu.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_acc_alu
// Purpose : Self-checking bench for serial_acc_alu against an arithmetic model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_serial_acc_alu;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             op_sub = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] operand = '0;
  logic [WIDTH-1:0] acc;
  logic             busy, done, carry_flag, ovf_flag, zero_flag;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: accumulator value and flags.
  logic [WIDTH-1:0] m_acc;
  logic             m_c, m_v, m_z;

  serial_acc_alu #(.WIDTH(WIDTH)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op_sub     (op_sub),
    .load       (load),
    .operand    (operand),
    .acc        (acc),
    .busy       (busy),
    .done       (done),
    .carry_flag (carry_flag),
    .ovf_flag   (ovf_flag),
    .zero_flag  (zero_flag)
  );

  always #5 clk = ~clk;

  // Model: plain (acc +/- operand) mod 2^WIDTH with the carry and overflow rules.
  task automatic model_op(input logic s, input logic [WIDTH-1:0] b);
    logic [WIDTH:0] full;
    if (s) full = {1'b0, m_acc} + {1'b0, ~b} + 1;
    else   full = {1'b0, m_acc} + {1'b0, b};
    if (s) m_v = (m_acc[WIDTH-1] != b[WIDTH-1]) && (full[WIDTH-1] != m_acc[WIDTH-1]);
    else   m_v = (m_acc[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != m_acc[WIDTH-1]);
    m_c   = full[WIDTH];
    m_acc = full[WIDTH-1:0];
    m_z   = (m_acc == '0);
  endtask

  task automatic model_load(input logic [WIDTH-1:0] v);
    m_acc = v; m_c = 1'b0; m_v = 1'b0; m_z = (v == '0);
  endtask

  // Drivers; each starts and ends at a falling edge.
  task automatic do_load(input logic [WIDTH-1:0] v);
    load = 1'b1; operand = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Returns in the done cycle; counts samples with busy high.
  task automatic run_op(input logic s, input logic [WIDTH-1:0] v,
                        output int nbusy, output bit got);
    start = 1'b1; op_sub = s; operand = v;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin got = 1'b1; break; end
      if (busy) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({acc, busy, done, carry_flag, ovf_flag, zero_flag} !== {8'h00, 5'b00001}) begin
      n_fail++;
      $display("FAIL reset: acc=%h busy=%b done=%b c=%b v=%b z=%b required acc=00 busy=0 done=0 c=0 v=0 z=1",
               acc, busy, done, carry_flag, ovf_flag, zero_flag);
    end
    rst = 1'b0;
    @(negedge clk);
    model_load('0);
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] pre [6] = '{8'h05, 8'h01, 8'h7F, 8'h80, 8'h03, 8'h05};
    logic             sb  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [WIDTH-1:0] opd [6] = '{8'h03, 8'hFF, 8'h01, 8'h01, 8'h05, 8'h05};
    logic [WIDTH-1:0] ea  [6] = '{8'h08, 8'h00, 8'h80, 8'h7F, 8'hFE, 8'h00};
    logic [2:0]       ecvz[6] = '{3'b000, 3'b101, 3'b010, 3'b110, 3'b000, 3'b101};
    int nb; bit got;
    for (int k = 0; k < 6; k++) begin
      do_load(pre[k]);
      model_load(pre[k]);
      run_op(sb[k], opd[k], nb, got);
      model_op(sb[k], opd[k]);
      n_checks++;
      if (!got || nb != WIDTH) begin
        n_fail++;
        $display("FAIL directed%0d latency: done=%b busy_cycles=%0d required done=1 busy_cycles=%0d",
                 k, got, nb, WIDTH);
      end
      n_checks++;
      if ({acc, carry_flag, ovf_flag, zero_flag} !== {ea[k], ecvz[k]}) begin
        n_fail++;
        $display("FAIL directed%0d result: acc=%h cvz=%b%b%b required acc=%h cvz=%b",
                 k, acc, carry_flag, ovf_flag, zero_flag, ea[k], ecvz[k]);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL directed%0d done_clear: done=%b busy=%b required 0 0", k, done, busy);
      end
    end
  endtask

  task automatic test_random();
    int nb; bit got;
    logic [WIDTH-1:0] v;
    logic s;
    for (int k = 0; k < 40; k++) begin
      v = WIDTH'($urandom);
      s = 1'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        do_load(v);
        model_load(v);
        n_checks++;
        if ({acc, carry_flag, ovf_flag, zero_flag, busy} !== {m_acc, m_c, m_v, m_z, 1'b0}) begin
          n_fail++;
          $display("FAIL random%0d load: acc=%h cvz=%b%b%b required acc=%h cvz=%b%b%b",
                   k, acc, carry_flag, ovf_flag, zero_flag, m_acc, m_c, m_v, m_z);
        end
      end else begin
        run_op(s, v, nb, got);
        model_op(s, v);
        n_checks++;
        if (!got || nb != WIDTH ||
            {acc, carry_flag, ovf_flag, zero_flag} !== {m_acc, m_c, m_v, m_z}) begin
          n_fail++;
          $display("FAIL random%0d op sub=%b b=%h: done=%b busy_cycles=%0d acc=%h cvz=%b%b%b required acc=%h cvz=%b%b%b",
                   k, s, v, got, nb, acc, carry_flag, ovf_flag, zero_flag, m_acc, m_c, m_v, m_z);
        end
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_midrun_ignore();
    int ndone = 0;
    do_load(8'h20);
    model_load(8'h20);
    start = 1'b1; op_sub = 1'b0; operand = 8'h10;
    @(negedge clk);
    start = 1'b0;
    model_op(1'b0, 8'h10);
    for (int i = 0; i < 15; i++) begin
      if (done) ndone++;
      if (i == 3) begin start = 1'b1; load = 1'b1; op_sub = 1'b1; operand = 8'h55; end
      if (i == 4) begin start = 1'b0; load = 1'b0; end
      @(negedge clk);
    end
    n_checks++;
    if (ndone != 1 || acc !== m_acc || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_ignore: dones=%0d acc=%h busy=%b required dones=1 acc=%h busy=0",
               ndone, acc, busy, m_acc);
    end
  endtask

  task automatic test_load_wins();
    load = 1'b1; start = 1'b1; op_sub = 1'b0; operand = 8'hA6;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    model_load(8'hA6);
    n_checks++;
    if ({acc, busy, carry_flag, ovf_flag, zero_flag} !== {8'hA6, 1'b0, 3'b000}) begin
      n_fail++;
      $display("FAIL load_wins: acc=%h busy=%b cvz=%b%b%b required acc=a6 busy=0 cvz=000",
               acc, busy, carry_flag, ovf_flag, zero_flag);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || acc !== 8'hA6) begin
      n_fail++;
      $display("FAIL load_wins_idle: busy=%b done=%b acc=%h required 0 0 a6", busy, done, acc);
    end
  endtask

  task automatic test_reset_midrun();
    int nb; bit got;
    do_load(8'h33);
    start = 1'b1; op_sub = 1'b0; operand = 8'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({acc, busy, done, carry_flag, ovf_flag, zero_flag} !== {8'h00, 5'b00001}) begin
      n_fail++;
      $display("FAIL reset_midrun: acc=%h busy=%b done=%b c=%b v=%b z=%b required acc=00 busy=0 done=0 c=0 v=0 z=1",
               acc, busy, done, carry_flag, ovf_flag, zero_flag);
    end
    model_load('0);
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) nb++;
      @(negedge clk);
    end
    n_checks++;
    if (nb != 0) begin
      n_fail++;
      $display("FAIL reset_no_done: active_cycles=%0d required 0", nb);
    end
    run_op(1'b0, 8'h05, nb, got);
    model_op(1'b0, 8'h05);
    n_checks++;
    if (!got || nb != WIDTH || acc !== m_acc) begin
      n_fail++;
      $display("FAIL reset_recover: done=%b busy_cycles=%0d acc=%h required done=1 busy_cycles=%0d acc=%h",
               got, nb, acc, WIDTH, m_acc);
    end
  endtask

  task automatic test_back_to_back();
    int nb; bit got;
    do_load(8'h40);
    model_load(8'h40);
    run_op(1'b0, 8'h25, nb, got);
    model_op(1'b0, 8'h25);
    n_checks++;
    if (!got || acc !== m_acc) begin
      n_fail++;
      $display("FAIL b2b_first: done=%b acc=%h required done=1 acc=%h", got, acc, m_acc);
    end
    run_op(1'b1, 8'h70, nb, got);
    model_op(1'b1, 8'h70);
    n_checks++;
    if (!got || nb != WIDTH ||
        {acc, carry_flag, ovf_flag, zero_flag} !== {m_acc, m_c, m_v, m_z}) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b busy_cycles=%0d acc=%h cvz=%b%b%b required acc=%h cvz=%b%b%b",
               got, nb, acc, carry_flag, ovf_flag, zero_flag, m_acc, m_c, m_v, m_z);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_midrun_ignore();
    test_load_wins();
    test_reset_midrun();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
